// File: rtl/load_store_align.sv
// RV32I load/store unit in front of a word-addressed data memory.
// Misaligned loads take two word reads; misaligned stores go out byte by byte.
module load_store_align #(
   parameter int DEPTH = 128,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [2:0]    req_funct3,
   input  logic [31:0]   req_addr,
   input  logic [31:0]   req_wdata,
   output logic          rsp_valid,
   output logic [31:0]   rsp_rdata,
   output logic          rsp_err,
   output logic [AW-1:0] mem_rd_addr,
   input  logic [31:0]   mem_rd_data,
   output logic [AW-1:0] mem_wr_addr,
   output logic [31:0]   mem_wr_data,
   output logic          mem_we,
   output logic [2:0]    mem_wr_strb
);

   typedef enum logic [2:0] {
      IDLE,
      RD0,
      RD1,
      WR,
      RESP
   } state_t;

   localparam logic [32:0] LIMIT = 33'(4 * DEPTH);
   localparam logic [2:0]  STRB_NOP = 3'b010;

   state_t        state_q, state_d;
   logic          we_q, we_d;
   logic [2:0]    f3_q, f3_d;
   logic [AW+1:0] addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [31:0]   word0_q, word0_d;
   logic [1:0]    cnt_q, cnt_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          err_q, err_d;

   logic [2:0]    req_size;
   logic [32:0]   req_last;
   logic          req_illegal;
   logic          req_hi_bad;
   logic          req_err;

   logic [2:0]    sz_q;
   logic          mis_q;
   logic          bytewise;
   logic          wr_last;
   logic [AW+1:0] baddr;
   logic [31:0]   wsh;

   function automatic logic [31:0] extract(
      input logic [31:0] w1,
      input logic [31:0] w0,
      input logic [1:0]  off,
      input logic [2:0]  f3
   );
      logic [63:0] sh;
      sh = {w1, w0} >> {off, 3'b000};
      case (f3)
         3'b000:  extract = {{24{sh[7]}}, sh[7:0]};
         3'b001:  extract = {{16{sh[15]}}, sh[15:0]};
         3'b100:  extract = {24'b0, sh[7:0]};
         3'b101:  extract = {16'b0, sh[15:0]};
         default: extract = sh[31:0];
      endcase
   endfunction

   // Request qualification, evaluated on the incoming request
   always_comb begin
      req_size = 3'd4;
      case (req_funct3[1:0])
         2'b00:   req_size = 3'd1;
         2'b01:   req_size = 3'd2;
         default: req_size = 3'd4;
      endcase
      req_last = {1'b0, req_addr} + 33'(req_size) - 33'd1;
      if (req_we) begin
         req_illegal = req_funct3 > 3'd2;
      end else begin
         req_illegal = req_funct3 inside {3'b011, 3'b110, 3'b111};
      end
      req_hi_bad = |req_addr[31:AW+2];
      req_err    = req_illegal | req_hi_bad | (req_last >= LIMIT);
   end

   always_comb begin
      sz_q = 3'd4;
      case (f3_q[1:0])
         2'b00:   sz_q = 3'd1;
         2'b01:   sz_q = 3'd2;
         default: sz_q = 3'd4;
      endcase
      mis_q = ((f3_q[1:0] == 2'b01) && addr_q[0]) ||
              ((f3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
      bytewise = mis_q || (sz_q == 3'd1);
      wr_last  = !mis_q || (cnt_q == 2'(sz_q - 3'd1));
      baddr    = addr_q + (AW+2)'(cnt_q);
      wsh      = wdata_q >> {cnt_q, 3'b000};
   end

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      f3_d    = f3_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      word0_d = word0_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               f3_d    = req_funct3;
               addr_d  = req_addr[AW+1:0];
               wdata_d = req_wdata;
               cnt_d   = 2'd0;
               if (req_err) begin
                  state_d = RESP;
                  rdata_d = 32'd0;
                  err_d   = 1'b1;
               end else begin
                  state_d = req_we ? WR : RD0;
               end
            end
         end
         RD0: begin
            word0_d = mem_rd_data;
            if (mis_q) begin
               state_d = RD1;
            end else begin
               state_d = RESP;
               rdata_d = extract(32'd0, mem_rd_data, addr_q[1:0], f3_q);
               err_d   = 1'b0;
            end
         end
         RD1: begin
            state_d = RESP;
            rdata_d = extract(mem_rd_data, word0_q, addr_q[1:0], f3_q);
            err_d   = 1'b0;
         end
         WR: begin
            if (wr_last) begin
               state_d = RESP;
               rdata_d = 32'd0;
               err_d   = 1'b0;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         f3_q    <= 3'd0;
         addr_q  <= '0;
         wdata_q <= 32'd0;
         word0_q <= 32'd0;
         cnt_q   <= 2'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         f3_q    <= f3_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         word0_q <= word0_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      mem_rd_addr = '0;
      case (state_q)
         RD0:     mem_rd_addr = addr_q[AW+1:2];
         RD1:     mem_rd_addr = addr_q[AW+1:2] + AW'(1);
         default: mem_rd_addr = '0;
      endcase
   end

   // Write port; a reset edge suppresses the write in flight
   always_comb begin
      mem_we      = 1'b0;
      mem_wr_addr = '0;
      mem_wr_data = 32'd0;
      mem_wr_strb = STRB_NOP;
      if (state_q == WR) begin
         mem_we = rst;
         if (bytewise) begin
            mem_wr_addr = baddr[AW+1:2];
            mem_wr_strb = {1'b1, baddr[1:0]};
            mem_wr_data = {24'b0, wsh[7:0]};
         end else if (sz_q == 3'd2) begin
            mem_wr_addr = addr_q[AW+1:2];
            mem_wr_strb = addr_q[1] ? 3'b011 : 3'b001;
            mem_wr_data = {16'b0, wdata_q[15:0]};
         end else begin
            mem_wr_addr = addr_q[AW+1:2];
            mem_wr_strb = 3'b000;
            mem_wr_data = wdata_q;
         end
      end
   end

   assign req_ready = (state_q == IDLE);
   assign rsp_valid = (state_q == RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

   logic unused_we;
   assign unused_we = we_q;

endmodule
